// File: rtl/pwl_pipe_gen_if.sv
// Sample/result streams and coefficient write port of the PWL evaluation pipeline.
// Handshake: a beat moves on a rising edge where valid & ready are both high;
// the producer keeps valid and payload stable until that edge, and ready may depend combinationally on the consumer's state.
interface pwl_pipe_gen_if #(
  parameter int DATA_W   = 16,
  parameter int SEG_BITS = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   x_in;
  logic [1:0]          mode_in;
  logic [DATA_W-1:0]   y_out;
  logic                sat_out;
  logic                out_valid;
  logic                out_ready;
  logic                cfg_we;
  logic                cfg_sel;
  logic [SEG_BITS-1:0] cfg_addr;
  logic [DATA_W-1:0]   cfg_slope;
  logic [DATA_W-1:0]   cfg_intercept;

  modport master (
    output in_valid, x_in, mode_in, out_ready,
    output cfg_we, cfg_sel, cfg_addr, cfg_slope, cfg_intercept,
    input  in_ready, y_out, sat_out, out_valid
  );

  modport slave (
    input  in_valid, x_in, mode_in, out_ready,
    input  cfg_we, cfg_sel, cfg_addr, cfg_slope, cfg_intercept,
    output in_ready, y_out, sat_out, out_valid
  );
endinterface

// File: rtl/pwl_pipe_gen.sv
// Four-stage, two-table piecewise-linear evaluator with programmable coefficients,
// per-sample mode select and a global stall driven by output backpressure.
module pwl_pipe_gen #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int SEG_BITS = 4
) (
  input logic            clk,
  input logic            rst_n,
  pwl_pipe_gen_if.slave  bus
);

  localparam int SEGS = 1 << SEG_BITS;
  localparam int PW   = 2 * DATA_W + 1;
  localparam int RW   = PW + 1;

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_B   = 2'd1,
    MODE_AB  = 2'd2,
    MODE_BYP = 2'd3
  } mode_t;

  typedef logic [DATA_W-1:0] word_t;

  // Returns {sat, y}: y = clamp((slope * x) >>> FRAC_W + intercept, 0, 2^DATA_W-1).
  function automatic logic [DATA_W:0] pwl_eval(input word_t slope, input word_t icpt, input word_t x);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] xa;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    logic signed [RW-1:0] r;
    sa = {{(PW-DATA_W){slope[DATA_W-1]}}, slope};
    xa = {{(PW-DATA_W){1'b0}}, x};
    p  = sa * xa;
    q  = p >>> FRAC_W;
    r  = {q[PW-1], q} + {{(RW-DATA_W){icpt[DATA_W-1]}}, icpt};
    if (r[RW-1])
      pwl_eval = {1'b1, {DATA_W{1'b0}}};
    else if (|r[RW-2:DATA_W])
      pwl_eval = {1'b1, {DATA_W{1'b1}}};
    else
      pwl_eval = {1'b0, r[DATA_W-1:0]};
  endfunction

  function automatic logic [SEG_BITS-1:0] seg(input word_t x);
    seg = x[DATA_W-1 -: SEG_BITS];
  endfunction

  word_t a_slope [SEGS];
  word_t a_icpt  [SEGS];
  word_t b_slope [SEGS];
  word_t b_icpt  [SEGS];

  logic  advance;

  logic  v1, v2, v3, v4;
  mode_t m1, m2, m3;
  word_t x1, sa1, ia1;
  word_t y2, y3, y4, sb3, ib3;
  logic  s2, s3, s4;

  logic [DATA_W:0] eval_a;
  logic [DATA_W:0] eval_b;

  assign advance       = ~v4 | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v4;
  assign bus.y_out     = y4;
  assign bus.sat_out   = s4;

  assign eval_a = pwl_eval(sa1, ia1, x1);
  assign eval_b = pwl_eval(sb3, ib3, y3);

  // Coefficient writes ignore the stall; reads sample the tables at S1/S3 capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEGS; i++) begin
        a_slope[i] <= '0;
        a_icpt[i]  <= '0;
        b_slope[i] <= '0;
        b_icpt[i]  <= '0;
      end
    end else if (bus.cfg_we) begin
      if (bus.cfg_sel) begin
        b_slope[bus.cfg_addr] <= bus.cfg_slope;
        b_icpt[bus.cfg_addr]  <= bus.cfg_intercept;
      end else begin
        a_slope[bus.cfg_addr] <= bus.cfg_slope;
        a_icpt[bus.cfg_addr]  <= bus.cfg_intercept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      v4  <= 1'b0;
      m1  <= MODE_A;
      m2  <= MODE_A;
      m3  <= MODE_A;
      x1  <= '0;
      sa1 <= '0;
      ia1 <= '0;
      y2  <= '0;
      s2  <= 1'b0;
      y3  <= '0;
      s3  <= 1'b0;
      sb3 <= '0;
      ib3 <= '0;
      y4  <= '0;
      s4  <= 1'b0;
    end else if (advance) begin
      v1  <= bus.in_valid;
      m1  <= mode_t'(bus.mode_in);
      x1  <= bus.x_in;
      sa1 <= a_slope[seg(bus.x_in)];
      ia1 <= a_icpt[seg(bus.x_in)];

      v2 <= v1;
      m2 <= m1;
      if (m1 == MODE_B || m1 == MODE_BYP)
        {s2, y2} <= {1'b0, x1};
      else
        {s2, y2} <= eval_a;

      v3  <= v2;
      m3  <= m2;
      y3  <= y2;
      s3  <= s2;
      sb3 <= b_slope[seg(y2)];
      ib3 <= b_icpt[seg(y2)];

      v4 <= v3;
      if (m3 == MODE_A || m3 == MODE_BYP)
        {s4, y4} <= {s3, y3};
      else
        {s4, y4} <= {s3 | eval_b[DATA_W], eval_b[DATA_W-1:0]};
    end
  end

endmodule

// File: tb/tb_pwl_pipe_gen.sv
// Directed bench for pwl_pipe_gen: driver tasks push expected {sat, y} into a queue,
// a negedge monitor pops and compares on every output transfer.
module tb_pwl_pipe_gen;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int SEG_BITS = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwl_pipe_gen_if #(.DATA_W(DATA_W), .SEG_BITS(SEG_BITS)) bus ();

  pwl_pipe_gen #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SEG_BITS(SEG_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W:0] exp_q[$];
  int              lat_q[$];
  logic            chk_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver tasks: callers enter just after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic [1:0] mode, input logic [DATA_W:0] exp);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.mode_in  = mode;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(chk_lat ? cyc : -1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: x=0x%0h never accepted, required acceptance within 50 cycles", x);
    end
  endtask

  task automatic cfg_write(input logic sel, input logic [SEG_BITS-1:0] addr,
                           input logic [DATA_W-1:0] slope, input logic [DATA_W-1:0] icpt);
    bus.cfg_we        = 1'b1;
    bus.cfg_sel       = sel;
    bus.cfg_addr      = addr;
    bus.cfg_slope     = slope;
    bus.cfg_intercept = icpt;
    sync();
    bus.cfg_we = 1'b0;
  endtask

  task automatic program_table(input logic sel, input logic [DATA_W-1:0] slope, input logic [DATA_W-1:0] icpt);
    for (int a = 0; a < (1 << SEG_BITS); a++)
      cfg_write(sel, SEG_BITS'(a), slope, icpt);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    sync();
  endtask

  // scoreboard monitor
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_y;
  logic              prev_sat;
  logic [DATA_W:0]   mon_e;
  int                mon_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_y", bus.y_out, prev_y);
        check("hold_sat", bus.sat_out, prev_sat);
      end
      if (bus.out_valid && !bus.out_ready)
        check("in_ready_stall", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got y=0x%0h with no sample outstanding", bus.y_out);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = lat_q.pop_front();
          check("y_out", bus.y_out, mon_e[DATA_W-1:0]);
          check("sat_out", bus.sat_out, mon_e[DATA_W]);
          if (mon_t >= 0) check("latency", cyc - mon_t, 4);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.y_out;
      prev_sat   = bus.sat_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.x_in          = '0;
    bus.mode_in       = '0;
    bus.out_ready     = 1'b1;
    bus.cfg_we        = 1'b0;
    bus.cfg_sel       = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_slope     = '0;
    bus.cfg_intercept = '0;
    chk_lat           = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", bus.out_valid, 0);
    check("reset_y", bus.y_out, 0);
    check("reset_sat", bus.sat_out, 0);
    check("reset_in_ready", bus.in_ready, 1);
    sync();
    rst_n = 1'b1;

    // reset mid-stream discards in-flight samples and clears the tables
    program_table(1'b0, 16'h0100, 16'h0000);
    send(16'h0011, 2'd0, {1'b0, 16'h0011});
    send(16'h0022, 2'd0, {1'b0, 16'h0022});
    send(16'h0033, 2'd0, {1'b0, 16'h0033});
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_y", bus.y_out, 0);
    check("midrst_sat", bus.sat_out, 0);
    sync();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_after_reset", bus.out_valid, 0);
    sync();
    send(16'h1234, 2'd0, {1'b0, 16'h0000});
    wait_drain();

    // identity table, bypass and segment selection
    program_table(1'b0, 16'h0100, 16'h0000);
    send(16'd1000, 2'd0, {1'b0, 16'd1000});
    send(16'hBEEF, 2'd3, {1'b0, 16'hBEEF});
    wait_drain();
    cfg_write(1'b0, 4'hF, 16'h0100, 16'hFFFF);
    send(16'hF000, 2'd0, {1'b0, 16'hEFFF});
    send(16'h1000, 2'd0, {1'b0, 16'h1000});
    wait_drain();

    // saturation high / low, negative slope
    program_table(1'b0, 16'h0400, 16'h0000);
    send(16'h8000, 2'd0, {1'b1, 16'hFFFF});
    wait_drain();
    program_table(1'b0, 16'h0000, 16'hFF9C);
    send(16'h0005, 2'd0, {1'b1, 16'h0000});
    wait_drain();
    program_table(1'b0, 16'hFF00, 16'h1000);
    send(16'h0800, 2'd0, {1'b0, 16'h0800});
    wait_drain();

    // chained and B-only modes
    program_table(1'b0, 16'h0200, 16'h0000);
    program_table(1'b1, 16'h0100, 16'h0010);
    send(16'h0100, 2'd2, {1'b0, 16'h0210});
    send(16'h0100, 2'd1, {1'b0, 16'h0110});
    wait_drain();
    cfg_write(1'b1, 4'hF, 16'h0000, 16'h0042);
    send(16'h8000, 2'd2, {1'b1, 16'h0042});
    send(16'h8000, 2'd1, {1'b0, 16'h8010});
    wait_drain();

    // backpressure over a 10-sample stream
    program_table(1'b0, 16'h0100, 16'h0000);
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send(16'(i), 2'd0, {1'b0, 16'(i)});
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk_lat = 1'b1;

    // coefficient write in the same cycle as sample acceptance
    bus.in_valid      = 1'b1;
    bus.x_in          = 16'h0010;
    bus.mode_in       = 2'd0;
    bus.cfg_we        = 1'b1;
    bus.cfg_sel       = 1'b0;
    bus.cfg_addr      = 4'h0;
    bus.cfg_slope     = 16'h0200;
    bus.cfg_intercept = 16'h0000;
    @(negedge clk);
    check("race_accept", bus.in_ready, 1);
    exp_q.push_back({1'b0, 16'h0010});
    lat_q.push_back(cyc);
    sync();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    send(16'h0010, 2'd0, {1'b0, 16'h0020});
    wait_drain();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
